// File: rtl/calc_pkg.sv
// Shared types and constants for the ALU result display path.
// Holds the converter FSM states, the BCD digit type and default sizes.
// Also holds the leading-zero blank rule used when new digits are latched.
package calc_pkg;

   // Default sizes: an 8-bit magnitude needs three decimal digits (max 255).
   localparam int WIDTH_DEF  = 8;
   localparam int DIGITS_DEF = 3;

   // Blank mask after reset: "0" is displayed with hundreds and tens dark.
   localparam logic [2:0] BLANK_RESET = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   // Leading-zero blanking {hundreds, tens, ones}.
   // Tens only blanks when hundreds is also blank. Ones always stays lit.
   function automatic logic [2:0] blank_mask(input bcd_t hund, input bcd_t ten);
      logic b_hund;
      logic b_ten;
      b_hund = (hund == 4'd0);
      b_ten  = b_hund && (ten == 4'd0);
      return {b_hund, b_ten, 1'b0};
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: a nibble of 5 or more gets +3 before the shift.
// Purely combinational, no latency; has no handshake and never stalls.
// Any carry out of the 4-bit sum is dropped; legal BCD inputs (0..9) never produce one.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  bcd_t digit_i,
   output bcd_t digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Converts the ALU magnitude to three BCD digits, one bit per clock, with sign and blanking.
// done pulses WIDTH+1 cycles after start is accepted; throughput is one result per WIDTH+2 cycles.
// start is only honoured in IDLE. Requests in SHIFT or DONE are dropped, not queued.
module result_bcd_converter
   import calc_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic             neg,
   output logic             busy,
   output logic             done,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic             sign,
   output logic [2:0]       blank
);

   // Working register: BCD digits in the upper nibbles, the binary magnitude in the low WIDTH bits.
   localparam int SR_W  = DIGITS * 4 + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Bit offsets of the three displayed digits inside the working register.
   localparam int ONES_LSB = WIDTH;
   localparam int TENS_LSB = WIDTH + 4;
   localparam int HUND_LSB = WIDTH + 8;

   state_t            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [SR_W-1:0]   sr_adj;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   bcd_t              hund_q, hund_d;
   bcd_t              tens_q, tens_d;
   bcd_t              ones_q, ones_d;
   logic              sign_q, sign_d;
   logic [2:0]        blank_q, blank_d;

   bcd_t              adj_digit [DIGITS];

   // One corrector per BCD nibble. All nibbles are corrected in parallel before each shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (sr_q[WIDTH + 4*g +: 4]),
         .digit_o (adj_digit[g])
      );
   end

   // Rebuild the working register with corrected nibbles; the binary part passes through unchanged.
   always_comb begin
      sr_adj = sr_q;
      for (int d = 0; d < DIGITS; d++) begin
         sr_adj[WIDTH + 4*d +: 4] = adj_digit[d];
      end
   end

   // State register: reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the counter value 1 marks the last of the WIDTH shifts.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values.
   // Displayed outputs change only when leaving DONE, so partial digits are never shown.
   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      busy_d  = (state_q != IDLE);
      done_d  = (state_q == DONE);
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      sign_d  = sign_q;
      blank_d = blank_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sr_d  = {{(DIGITS*4){1'b0}}, value};
               neg_d = neg;
               cnt_d = CNT_W'(WIDTH);
            end
         end
         SHIFT: begin
            sr_d  = sr_adj << 1;
            cnt_d = cnt_q - CNT_W'(1);
         end
         DONE: begin
            // The last shift is not followed by a correction, so the nibbles are already final.
            hund_d  = sr_q[HUND_LSB +: 4];
            tens_d  = sr_q[TENS_LSB +: 4];
            ones_d  = sr_q[ONES_LSB +: 4];
            sign_d  = neg_q;
            blank_d = blank_mask(sr_q[HUND_LSB +: 4], sr_q[TENS_LSB +: 4]);
         end
         default: begin
            sr_d = sr_q;
         end
      endcase
   end

   // Datapath and output registers.
   // busy and done are registered, so they trail the state by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hund_q  <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         sign_q  <= 1'b0;
         blank_q <= BLANK_RESET;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         sign_q  <= sign_d;
         blank_q <= blank_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hundreds = hund_q;
   assign tens     = tens_q;
   assign ones     = ones_q;
   assign sign     = sign_q;
   assign blank    = blank_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter.
// Uses vector tables, hand sequences for timing corners, and random and swept values against a decimal model.
// Inputs change 1ns after the rising edge, and outputs are sampled at that same point.
module tb_result_bcd_converter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] value;
   logic       neg;
   logic       busy;
   logic       done;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       sign;
   logic [2:0] blank;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] v;
      logic       n;
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic       s;
      logic [2:0] b;
   } vec_t;

   vec_t vecs [8];

   result_bcd_converter dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .value    (value),
      .neg      (neg),
      .busy     (busy),
      .done     (done),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .sign     (sign),
      .blank    (blank)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decimal reference: digits from plain division, with blanking from the display rule.
   // Returns {h, t, o, sign, blank}.
   function automatic logic [15:0] ref_model(input int v, input logic n);
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic       bh;
      logic       bt;
      h  = 4'(v / 100);
      t  = 4'((v / 10) % 10);
      o  = 4'(v % 10);
      bh = (h == 4'd0);
      bt = bh && (t == 4'd0);
      return {h, t, o, n, bh, bt, 1'b0};
   endfunction

   function automatic logic [15:0] dut_word();
      return {hundreds, tens, ones, sign, blank};
   endfunction

   // Issues a start pulse, then waits a bounded time for done. lat is the number of cycles after acceptance.
   task automatic convert(input logic [7:0] v, input logic n, output int lat, output bit ok);
      value = v;
      neg   = n;
      start = 1'b1;
      step();
      start = 1'b0;
      value = 8'($urandom);
      neg   = 1'($urandom);
      lat   = 0;
      ok    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         lat++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int         lat;
      bit         ok;
      int         dcount;
      logic [3:0] dh, dt, d_o;
      int         last_done;
      logic [15:0] prev;
      bit         stable;
      bit         got;

      vecs[0] = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5, 1'b0, 3'b000};
      vecs[1] = '{8'd37,  1'b1, 4'd0, 4'd3, 4'd7, 1'b1, 3'b100};
      vecs[2] = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b110};
      vecs[3] = '{8'd9,   1'b0, 4'd0, 4'd0, 4'd9, 1'b0, 3'b110};
      vecs[4] = '{8'd100, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 3'b000};
      vecs[5] = '{8'd10,  1'b1, 4'd0, 4'd1, 4'd0, 1'b1, 3'b100};
      vecs[6] = '{8'd200, 1'b0, 4'd2, 4'd0, 4'd0, 1'b0, 3'b000};
      vecs[7] = '{8'd0,   1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 3'b110};

      rst   = 1'b1;
      start = 1'b0;
      value = 8'd0;
      neg   = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset_busy",  {31'd0, busy}, 32'd0);
      chk("reset_done",  {31'd0, done}, 32'd0);
      chk("reset_digits", {20'd0, hundreds, tens, ones}, 32'd0);
      chk("reset_sign",  {31'd0, sign}, 32'd0);
      chk("reset_blank", {29'd0, blank}, 32'b110);

      // Reset partway through a conversion of 200: the run is aborted and no done pulse follows.
      value = 8'd200;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("midrst_busy",   {31'd0, busy}, 32'd0);
      chk("midrst_done",   {31'd0, done}, 32'd0);
      chk("midrst_digits", {20'd0, hundreds, tens, ones}, 32'd0);
      chk("midrst_blank",  {29'd0, blank}, 32'b110);
      dcount = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (done) dcount++;
      end
      chk("midrst_no_done", dcount, 32'd0);

      // Cycle-exact check of busy and done for 255. Cycle 0 is the cycle right after the accepting edge.
      value = 8'd255;
      neg   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      value = 8'd1;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("t255_busy_c%0d", k), {31'd0, busy}, {31'd0, (k >= 1 && k <= 9)});
         chk($sformatf("t255_done_c%0d", k), {31'd0, done}, {31'd0, (k == 9)});
         if (k == 9) chk("t255_word", {16'd0, dut_word()}, {16'd0, 4'd2, 4'd5, 4'd5, 1'b0, 3'b000});
         step();
      end

      // Table of vectors with hand-computed expectations.
      for (int i = 0; i < 8; i++) begin
         convert(vecs[i].v, vecs[i].n, lat, ok);
         chk($sformatf("vec%0d_done_seen", i), {31'd0, ok}, 32'd1);
         chk($sformatf("vec%0d_latency", i), lat, 32'd9);
         chk($sformatf("vec%0d_word", i), {16'd0, dut_word()},
             {16'd0, vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].s, vecs[i].b});
         step();
      end

      // Extra starts in SHIFT (sampled at edge +3) and in DONE (edge +9) must be ignored.
      // value changes to 99 after acceptance must not affect the conversion of 12.
      value = 8'd12;
      neg   = 1'b0;
      start = 1'b1;
      step();
      dcount = 0;
      dh = 4'hF; dt = 4'hF; d_o = 4'hF;
      for (int k = 0; k < 25; k++) begin
         start = (k == 2 || k == 8);
         value = 8'd99;
         if (done) begin
            dcount++;
            dh = hundreds; dt = tens; d_o = ones;
         end
         step();
      end
      start = 1'b0;
      chk("ignore_start_one_done", dcount, 32'd1);
      chk("ignore_start_digits", {20'd0, dh, dt, d_o}, {20'd0, 4'd0, 4'd1, 4'd2});

      // Random values against the decimal model.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] rv;
         logic       rn;
         rv = 8'($urandom);
         rn = 1'($urandom);
         convert(rv, rn, lat, ok);
         chk($sformatf("rand%0d_done_seen", i), {31'd0, ok}, 32'd1);
         chk($sformatf("rand%0d_v%0d_word", i, rv), {16'd0, dut_word()}, {16'd0, ref_model(int'(rv), rn)});
         step();
      end

      // Hold start high and sweep 0..255. The gap between done pulses is 10 cycles,
      // and the outputs hold still between pulses.
      value = 8'd0;
      neg   = 1'b0;
      start = 1'b1;
      step();
      last_done = -1;
      for (int v = 0; v < 256; v++) begin
         logic n_acc;
         n_acc = 1'(v % 2);
         if (v == 0) n_acc = 1'b0;
         prev   = dut_word();
         value  = 8'($urandom);
         neg    = 1'($urandom);
         stable = 1'b1;
         got    = 1'b0;
         for (int k = 0; k < 15; k++) begin
            if (done) begin
               got = 1'b1;
               break;
            end
            if (dut_word() !== prev) stable = 1'b0;
            step();
         end
         chk($sformatf("sweep%0d_done_seen", v), {31'd0, got}, 32'd1);
         if (!got) break;
         chk($sformatf("sweep%0d_stable", v), {31'd0, stable}, 32'd1);
         chk($sformatf("sweep%0d_word", v), {16'd0, dut_word()}, {16'd0, ref_model(v, n_acc)});
         if (last_done >= 0) chk($sformatf("sweep%0d_gap", v), cyc - last_done, 32'd10);
         last_done = cyc;
         // In the done cycle the FSM is back in IDLE, so the next edge accepts the next value.
         value = 8'(v + 1);
         neg   = 1'((v + 1) % 2);
         if (v == 255) start = 1'b0;
         step();
      end
      start = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Sits directly downstream of the calculator ALU.
- Takes the ALU's 8-bit magnitude result and its negative flag.
- Converts the magnitude to three BCD digits with an iterative shift-add-3 (double dabble) sequence, one bit per clock, and registers sign and leading-zero blanking for the 7-segment display driver.
- Uses a start/busy/done handshake so the controller can launch one conversion per ALU result.

Parameters:
WIDTH, 8, bit width of the unsigned input magnitude
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE
value  input  WIDTH  unsigned magnitude from ALU out
neg  input  1  ALU negative flag, captured with value
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are valid
hundreds  output  4  BCD digit 2 (MSD)
tens  output  4  BCD digit 1
ones  output  4  BCD digit 0
sign  output  1  registered copy of neg for the displayed result
blank  output  3  leading-zero blank mask {hundreds,tens,ones}; ones is never blanked

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: state=IDLE; busy=0, done=0, hundreds=tens=ones=0, sign=0, blank=3'b110; shift register and counter cleared. A reset mid-conversion aborts it with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load shift register {DIGITS*4'b0, value}, capture neg, counter=WIDTH, go to SHIFT.
  - busy rises in the next cycle.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3 (4-bit, no carry out).
  - Then the whole register shifts left by 1 and counter decrements.
  - After the WIDTH-th shift, go to DONE.
  - Exactly WIDTH cycles in SHIFT.
- DONE, one cycle:
  - Output registers load from the BCD nibbles; sign is loaded with the captured neg.
  - blank[2]=(hundreds==0); blank[1]=blank[2]&&(tens==0); blank[0]=0.
  - done=1 and busy=1 for this cycle; next state IDLE.
- Latency: start sampled at edge N → done high in the cycle after edge N+WIDTH+1 (cycle 9 after start for WIDTH=8). Throughput is one conversion per WIDTH+2 cycles.
- busy is high from the cycle after start acceptance through the DONE cycle inclusive.
- start is ignored in SHIFT and DONE; no queuing.
- start held continuously high re-triggers on the first IDLE cycle after DONE.
- value and neg are sampled only at acceptance; later changes do not affect the conversion in progress.
- Output digits, sign and blank hold their last values until the next DONE; never visibly partial.
- Arithmetic: max value 255 → 2,5,5; the hundreds nibble never exceeds 2 for WIDTH=8.
- Shift register width DIGITS*4+WIDTH. Counter width $clog2(WIDTH+1).
- neg is passed through without regard to value; a neg=1 with value=0 displays -0, which is the ALU's responsibility.

Decomposition:
- Shared package calc_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD digit typedef (logic [3:0])
  - DIGITS and WIDTH defaults
  - blank-mask constant BLANK_RESET=3'b110
- One sub-module, bcd_digit_adj: combinational 4-bit "if >= 5 add 3" corrector, instantiated DIGITS times in a generate loop.

Test Plan:
1. Assert rst for 2 cycles mid-conversion (started with value=200) → next cycle busy=0, done=0, digits 0/0/0, blank=3'b110; no done pulse follows.
2. value=255, neg=0, start pulse → done pulses exactly 9 cycles after start; digits 2/5/5, sign=0, blank=3'b000; busy high for cycles 1–9.
3. value=37, neg=1 → digits 0/3/7, sign=1, blank=3'b100.
4. value=0 → digits 0/0/0, blank=3'b110. value=9 → 0/0/9, blank=3'b110. value=100 → 1/0/0, blank=3'b000.
5. start=1 at cycle 0 (value=12), pulse start again with value=99 at cycles 3 and 9 → only one done, digits 0/1/2; value change during SHIFT has no effect.
6. start held high with value stepping 0..255 → each result matches the decimal reference model. Consecutive done pulses are 10 cycles apart, and digits are stable between pulses.
